// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler
// Brief    : Arbitrates the 4-digit seven-segment display between the stopwatch
//            and a message source; frame-aligned owner switch plus blanked scan.
// Revision : 1.0 - initial release
// ============================================================================
module display_scheduler #(
    parameter int unsigned SCAN_DIV     = 250000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned HOLD_TICKS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic [15:0] sw_digits,
    input  logic        msg_req,
    input  logic [15:0] msg_digits,
    output logic        msg_grant,
    input  logic [3:0]  blank_mask,
    output logic        owner,
    output logic [3:0]  D,
    output logic [3:0]  anode
);

    localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [0:0] {
        SW  = 1'b0,
        MSG = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_HW-1:0]   r_hold;
    logic [c_HW-1:0]   w_hold_nxt;
    logic              w_grant;
    logic              r_grant;

    logic [c_PW-1:0]   r_p;
    logic [1:0]        r_i;
    logic              w_wrap;
    logic              w_frame;
    logic [15:0]       r_snap;
    logic              r_own;
    logic              r_owner;
    logic [3:0]        r_d;
    logic [3:0]        r_anode;
    logic              w_dark;

    // Arbiter: a request always wins over a coincident second tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_grant     = 1'b0;
        if (msg_req) begin
            w_state_nxt = MSG;
            w_hold_nxt  = c_HW'(HOLD_TICKS);
            w_grant     = 1'b1;
        end else if (r_state == MSG && sec_tick) begin
            if (r_hold == c_HW'(1)) begin
                w_state_nxt = SW;
                w_hold_nxt  = '0;
            end else begin
                w_hold_nxt  = r_hold - c_HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SW;
            r_hold  <= '0;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_grant <= w_grant;
        end
    end

    assign w_wrap  = (r_p == c_PW'(SCAN_DIV - 1));
    assign w_frame = w_wrap && (r_i == 2'd3);
    assign w_dark  = (32'(r_p) < BLANK_CYCLES) || blank_mask[r_i];

    // r_owner trails r_own by one cycle so it flips together with the first
    // new digit on D, which itself lags the scan counters by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_i     <= '0;
            r_snap  <= '0;
            r_own   <= 1'b0;
            r_owner <= 1'b0;
            r_d     <= '0;
            r_anode <= 4'b1111;
        end else begin
            r_p     <= w_wrap ? '0 : r_p + c_PW'(1);
            if (w_wrap) begin
                r_i <= r_i + 2'd1;
            end
            if (w_frame) begin
                r_own  <= (r_state == MSG);
                r_snap <= (r_state == MSG) ? msg_digits : sw_digits;
            end
            r_owner <= r_own;
            r_d     <= r_snap[{r_i, 2'b00} +: 4];
            r_anode <= w_dark ? 4'b1111 : ~(4'b0001 << r_i);
        end
    end

    assign msg_grant = r_grant;
    assign owner     = r_owner;
    assign D         = r_d;
    assign anode     = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scheduler
// Brief    : Directed self-checking bench for display_scheduler (8/2/2 sizing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec_tick = 1'b0;
    logic [15:0] sw_digits = 16'h1234;
    logic        msg_req = 1'b0;
    logic [15:0] msg_digits = 16'h0000;
    logic        msg_grant;
    logic [3:0]  blank_mask = 4'b0000;
    logic        owner;
    logic [3:0]  D;
    logic [3:0]  anode;

    int n_chk = 0;
    int n_err = 0;

    display_scheduler #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .HOLD_TICKS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_tick  (sec_tick),
        .sw_digits (sw_digits),
        .msg_req   (msg_req),
        .msg_digits(msg_digits),
        .msg_grant (msg_grant),
        .blank_mask(blank_mask),
        .owner     (owner),
        .D         (D),
        .anode     (anode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts on the first cycle of a frame; checks the 32 output cycles it drives.
    task automatic check_frame(input logic [15:0] digits, input logic [3:0] mask,
                               input logic own, input string name);
        logic [3:0] exp_an;
        logic [3:0] exp_d;
        for (int j = 0; j < 32; j++) begin
            int p;
            int i;
            tick();
            p      = j % 8;
            i      = j / 8;
            exp_d  = digits[4*i +: 4];
            exp_an = (p < 2 || mask[i]) ? 4'b1111 : ~(4'b0001 << i);
            chk($sformatf("%s_anode_j%0d", name, j), {12'h0, anode}, {12'h0, exp_an});
            chk($sformatf("%s_D_j%0d", name, j), {12'h0, D}, {12'h0, exp_d});
            chk($sformatf("%s_owner_j%0d", name, j), {15'h0, owner}, {15'h0, own});
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_anode", {12'h0, anode}, 16'h000F);
        chk("rst_D", {12'h0, D}, 16'h0000);
        chk("rst_owner", {15'h0, owner}, 16'h0000);
        chk("rst_grant", {15'h0, msg_grant}, 16'h0000);
        rst = 1'b0;

        // Frame 0 shows the reset snapshot, frame 1 the stopwatch
        check_frame(16'h0000, 4'b0000, 1'b0, "f0");
        check_frame(16'h1234, 4'b0000, 1'b0, "f1");
        blank_mask = 4'b0100;
        check_frame(16'h1234, 4'b0100, 1'b0, "f2mask");
        blank_mask = 4'b0000;

        // Takeover requested at slot 1 (cycle 104)
        msg_digits = 16'h0112;
        repeat (8) tick();
        msg_req = 1'b1;
        tick();
        chk("grant_pulse", {15'h0, msg_grant}, 16'h0001);
        msg_req = 1'b0;
        tick();
        chk("grant_single", {15'h0, msg_grant}, 16'h0000);
        repeat (22) tick();
        chk("owner_pre_boundary", {15'h0, owner}, 16'h0000);
        check_frame(16'h0112, 4'b0000, 1'b1, "f4msg");

        // Hold expiry: two ticks, release at next boundary
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        repeat (3) tick();
        sec_tick = 1'b1;
        tick();
        sec_tick  = 1'b0;
        sw_digits = 16'h5678;
        repeat (27) tick();
        chk("owner_hold_frame_end", {15'h0, owner}, 16'h0001);
        check_frame(16'h5678, 4'b0000, 1'b0, "f6sw");

        // Retrigger coincident with the second tick keeps ownership
        msg_req = 1'b1;
        tick();
        chk("grant_req2", {15'h0, msg_grant}, 16'h0001);
        msg_req  = 1'b0;
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        tick();
        msg_req  = 1'b1;
        sec_tick = 1'b1;
        tick();
        chk("grant_retrig", {15'h0, msg_grant}, 16'h0001);
        msg_req  = 1'b0;
        sec_tick = 1'b1;
        tick();
        chk("grant_retrig_end", {15'h0, msg_grant}, 16'h0000);
        sec_tick = 1'b0;
        repeat (27) tick();
        check_frame(16'h0112, 4'b0000, 1'b1, "f8retrig");
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        repeat (31) tick();
        chk("owner_after_one_tick", {15'h0, owner}, 16'h0001);
        check_frame(16'h5678, 4'b0000, 1'b0, "f10sw");

        // Reset mid-frame while the message owns the display (p=5, i=2)
        msg_req = 1'b1;
        tick();
        msg_req = 1'b0;
        repeat (31) tick();
        repeat (21) tick();
        chk("owner_before_rst", {15'h0, owner}, 16'h0001);
        rst     = 1'b1;
        msg_req = 1'b1;
        tick();
        chk("rst2_anode", {12'h0, anode}, 16'h000F);
        chk("rst2_D", {12'h0, D}, 16'h0000);
        chk("rst2_owner", {15'h0, owner}, 16'h0000);
        chk("rst2_grant", {15'h0, msg_grant}, 16'h0000);
        rst     = 1'b0;
        msg_req = 1'b0;
        check_frame(16'h0000, 4'b0000, 1'b0, "f_after_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
